mat_unpad: RTL and testbench

- Output-side counterpart of the A/B input padder for the systolic array.
- Captures the array's flat BW-wide C result matrix in one cycle and keeps only the active N x M window.
- Streams the window out row-major, one BW-bit element per handshake, toward the result write-back path.
- Tags each element with its row/column and flags the last one.

---
 rtl/mat_unpad.sv | 150 +++++++++++++++
 tb/tb_mat_unpad.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_unpad.sv
// Captures the array's C matrix and streams the active N x M window row-major, one element per valid/ready handshake.
// First element appears the cycle after capture; 1 element/cycle sustained; outputs hold while ready_i is low.
module mat_unpad #(
  parameter  int DW      = 8,
  parameter  int BW      = 32,
  localparam int MAX_DIM = BW / DW
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            capture_i,
  input  logic [BW*MAX_DIM*MAX_DIM-1:0]   c_flat_in,
  input  logic [1:0]                      N_i,
  input  logic [1:0]                      M_i,
  input  logic                            ready_i,
  output logic [BW-1:0]                   data_o,
  output logic                            valid_o,
  output logic [1:0]                      row_o,
  output logic [1:0]                      col_o,
  output logic                            last_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int CW = BW * MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mat_q, mat_d;
  logic [2:0]      n_q, n_d;
  logic [2:0]      m_q, m_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [BW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic [1:0]      row_nx, col_nx;

  function automatic logic [BW-1:0] elem(input logic [CW-1:0] m,
                                         input logic [1:0] r,
                                         input logic [1:0] c);
    int idx;
    idx = int'(r) * MAX_DIM + int'(c);
    return m[idx*BW +: BW];
  endfunction

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    n_d     = n_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = done_q;

    // Row-major successor of the element currently presented.
    row_nx = row_q;
    col_nx = col_q + 2'd1;
    if ({1'b0, col_q} == m_q - 3'd1) begin
      col_nx = 2'd0;
      row_nx = row_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        if (capture_i) begin
          mat_d   = c_flat_in;
          n_d     = {1'b0, N_i} + 3'd1;
          m_d     = {1'b0, M_i} + 3'd1;
          row_d   = 2'd0;
          col_d   = 2'd0;
          data_d  = elem(c_flat_in, 2'd0, 2'd0);
          valid_d = 1'b1;
          last_d  = (N_i == 2'd0) && (M_i == 2'd0);
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_d  = row_nx;
            col_d  = col_nx;
            data_d = elem(mat_q, row_nx, col_nx);
            last_d = ({1'b0, row_nx} == n_q - 3'd1) && ({1'b0, col_nx} == m_q - 3'd1);
          end
        end
      end
      DONE: begin
        // Hold done until capture drops so a held capture cannot retrigger.
        if (!capture_i) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      mat_q   <= '0;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      n_q     <= n_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q == SEND);
  assign done_o  = done_q;

endmodule

// File: tb/tb_mat_unpad.sv
// Directed + randomized bench for mat_unpad against a queue-based row-major window model.
module tb_mat_unpad;

  localparam int DW = 8;
  localparam int BW = 32;
  localparam int MD = BW / DW;

  logic                  clk_i = 1'b0;
  logic                  reset_ni;
  logic                  capture_i;
  logic [BW*MD*MD-1:0]   c_flat_in;
  logic [1:0]            N_i, M_i;
  logic                  ready_i;
  logic [BW-1:0]         data_o;
  logic                  valid_o, last_o, busy_o, done_o;
  logic [1:0]            row_o, col_o;

  mat_unpad #(.DW(DW), .BW(BW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .capture_i(capture_i), .c_flat_in(c_flat_in),
    .N_i(N_i), .M_i(M_i), .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o),
    .row_o(row_o), .col_o(col_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] mat [MD][MD];

  typedef struct packed {
    logic [BW-1:0] d;
    logic [1:0]    r;
    logic [1:0]    c;
    logic          l;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        mat[r][c] = (mode == 0) ? BW'(16 * r + c + 1) : BW'($urandom);
  endtask

  task automatic pack();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        c_flat_in[(r*MD+c)*BW +: BW] = mat[r][c];
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o),  64'd0);
    chk({tag, "_last"},  64'(last_o),  64'd0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 three-cycle stall on column 1.
  task automatic run_drain(input int n, input int m, input int rmode, input bit hold, input int abort);
    int   cyc;
    int   xfers;
    int   stall;
    exp_t e;
    cyc = 0; xfers = 0; stall = 0;
    expq.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < m; c++) begin
        e.d = mat[r][c];
        e.r = r[1:0];
        e.c = c[1:0];
        e.l = (r == n - 1) && (c == m - 1);
        expq.push_back(e);
      end
    pack();
    N_i = 2'(n - 1);
    M_i = 2'(m - 1);
    capture_i = 1'b1;
    tick();
    if (!hold) capture_i = 1'b0;
    c_flat_in = {(MD*MD){$urandom}};
    N_i = 2'($urandom);
    M_i = 2'($urandom);
    while (expq.size() > 0 && cyc < 200) begin
      if (abort >= 0 && xfers == abort) return;
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          ready_i = !(expq[0].c == 2'd1 && stall < 3);
          if (!ready_i) stall++;
        end
      endcase
      chk("send_valid", 64'(valid_o), 64'd1);
      chk("send_busy",  64'(busy_o),  64'd1);
      chk("send_done",  64'(done_o),  64'd0);
      chk("data",       64'(data_o),  64'(expq[0].d));
      chk("row",        64'(row_o),   64'(expq[0].r));
      chk("col",        64'(col_o),   64'(expq[0].c));
      chk("last",       64'(last_o),  64'(expq[0].l));
      if (ready_i) begin
        void'(expq.pop_front());
        xfers++;
      end
      tick();
      cyc++;
    end
    chk("drain_complete", 64'(expq.size()), 64'd0);
    chk("xfer_count", 64'(xfers), 64'(n * m));
    if (rmode == 0) chk("throughput_cycles", 64'(cyc), 64'(n * m));
    if (rmode == 2) chk("stall_cycles", 64'(stall), 64'd3);
    chk_idle_outputs("after_last");
    chk("done_rise", 64'(done_o), 64'd1);
    if (hold) begin
      repeat (3) begin
        ready_i = 1'b1;
        tick();
        chk("done_hold", 64'(done_o), 64'd1);
        chk_idle_outputs("hold_no_restart");
      end
      capture_i = 1'b0;
    end
    tick();
    chk("done_fall", 64'(done_o), 64'd0);
    chk_idle_outputs("back_idle");
  endtask

  initial begin
    reset_ni  = 1'b0;
    capture_i = 1'b0;
    ready_i   = 1'b0;
    N_i       = '0;
    M_i       = '0;
    c_flat_in = '0;
    tick();
    tick();
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_row",  64'(row_o),  64'd0);
    chk("rst_col",  64'(col_o),  64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk_idle_outputs("rst");
    reset_ni = 1'b1;
    tick();
    chk_idle_outputs("idle_no_capture");

    // Full 4x4, streaming.
    fill(0);
    run_drain(4, 4, 0, 1'b0, -1);

    // Partial 2x3 window.
    fill(0);
    run_drain(2, 3, 0, 1'b0, -1);

    // 1x4 with a stall on element (0,1).
    fill(1);
    run_drain(1, 4, 2, 1'b0, -1);

    // 1x1 single element.
    fill(1);
    mat[0][0] = 32'hDEADBEEF;
    run_drain(1, 1, 0, 1'b0, -1);

    // Reset after 5 of 16 transfers, then a clean restart.
    fill(1);
    run_drain(4, 4, 0, 1'b0, 5);
    reset_ni = 1'b0;
    tick();
    chk("midrst_data", 64'(data_o), 64'd0);
    chk("midrst_row",  64'(row_o),  64'd0);
    chk("midrst_col",  64'(col_o),  64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk_idle_outputs("midrst");
    reset_ni = 1'b1;
    ready_i  = 1'b1;
    repeat (3) begin
      tick();
      chk_idle_outputs("post_rst_quiet");
    end
    fill(1);
    run_drain(4, 4, 0, 1'b0, -1);

    // Capture held through the drain, then a fresh capture.
    fill(1);
    run_drain(3, 2, 0, 1'b1, -1);
    fill(1);
    run_drain(2, 2, 1, 1'b0, -1);

    // Random shapes with random backpressure.
    for (int k = 0; k < 8; k++) begin
      fill(1);
      run_drain($urandom_range(1, 4), $urandom_range(1, 4), 1, bit'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
